// File: rtl/push_arbiter.sv
// Two-button push arbiter: synchronizes and debounces two raw pushbuttons, then
// reports which button was pressed first in each round (or a same-cycle tie).
module push_arbiter #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_l,
  input  logic pb_r,
  output logic winrnd,
  output logic right,
  output logic tie,
  output logic ready
);

  typedef enum logic [1:0] {
    ST_WAIT_REL = 2'b00,
    ST_IDLE     = 2'b01
  } state_t;

  localparam logic [7:0] LP_DB_LAST = 8'(DB_CYCLES - 1);

  // Channel index 0 is the left button, index 1 the right button.
  logic [1:0] w_pbRaw;
  logic [1:0] r_sync1;
  logic [1:0] r_sync2;
  logic [1:0] r_deb;
  logic [7:0] r_cnt [2];
  logic [1:0] r_quietCnt;
  logic       w_quiet;

  state_t r_state;
  state_t w_stateNext;
  logic   r_winrnd;
  logic   r_tie;
  logic   r_right;
  logic   r_ready;
  logic   w_winrndNext;
  logic   w_tieNext;
  logic   w_rightNext;
  logic   w_readyNext;

  assign w_pbRaw = {pb_r, pb_l};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_pbRaw;
      r_sync2 <= r_sync1;
    end
  end

  // The level flips on the DB_CYCLES-th consecutive differing sample; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_deb    <= '0;
      r_cnt[0] <= '0;
      r_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] >= LP_DB_LAST) begin
          r_deb[i] <= r_sync2[i];
          r_cnt[i] <= '0;
        end else if (r_cnt[i] != 8'hFF) begin
          r_cnt[i] <= r_cnt[i] + 8'd1;
        end
      end
    end
  end

  // Re-arming also needs the synchronizer stages to have been low for a couple of
  // cycles, so a button held through reset release cannot arm the arbiter.
  assign w_quiet = (r_sync1 == 2'b00) && (r_sync2 == 2'b00) && (r_deb == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_quietCnt <= '0;
    end else if (!w_quiet) begin
      r_quietCnt <= '0;
    end else if (r_quietCnt != 2'b11) begin
      r_quietCnt <= r_quietCnt + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_WAIT_REL;
      r_winrnd <= 1'b0;
      r_tie    <= 1'b0;
      r_right  <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_winrnd <= w_winrndNext;
      r_tie    <= w_tieNext;
      r_right  <= w_rightNext;
      r_ready  <= w_readyNext;
    end
  end

  always_comb begin
    w_stateNext  = ST_WAIT_REL;
    w_winrndNext = 1'b0;
    w_tieNext    = 1'b0;
    w_rightNext  = r_right;
    w_readyNext  = 1'b0;
    case (r_state)
      ST_WAIT_REL: begin
        if (w_quiet && (r_quietCnt >= 2'd2)) begin
          w_stateNext = ST_IDLE;
          w_readyNext = 1'b1;
        end
      end
      ST_IDLE: begin
        case (r_deb)
          2'b00: begin
            w_stateNext = ST_IDLE;
            w_readyNext = 1'b1;
          end
          2'b01: begin
            w_winrndNext = 1'b1;
            w_rightNext  = 1'b0;
          end
          2'b10: begin
            w_winrndNext = 1'b1;
            w_rightNext  = 1'b1;
          end
          default: begin
            w_winrndNext = 1'b1;
            w_tieNext    = 1'b1;
          end
        endcase
      end
      default: begin
        w_stateNext = ST_WAIT_REL;
      end
    endcase
  end

  assign winrnd = r_winrnd;
  assign tie    = r_tie;
  assign right  = r_right;
  assign ready  = r_ready;

endmodule

// File: tb/tb_push_arbiter.sv
// Directed self-checking bench for push_arbiter: expected round results are queued
// when a press is driven and checked by a monitor whenever winrnd pulses.
module tb_push_arbiter;

  localparam int DB = 4;

  typedef struct packed {
    logic right;
    logic tie;
  } exp_t;

  logic clk;
  logic rst;
  logic pbL;
  logic pbR;
  logic winrnd;
  logic right;
  logic tie;
  logic ready;

  exp_t sbQ[$];
  int   nAssert;
  int   nFail;
  logic prevWin;

  push_arbiter #(.DB_CYCLES(DB)) dut (
    .clk    (clk),
    .rst    (rst),
    .pb_l   (pbL),
    .pb_r   (pbR),
    .winrnd (winrnd),
    .right  (right),
    .tie    (tie),
    .ready  (ready)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic r);
    @(negedge clk);
    pbL = l;
    pbR = r;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitReady(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ready) break;
    end
    checkOutput(tag, ready, 1'b1);
  endtask

  task automatic waitPulse(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (sbQ.size() == 0) break;
    end
    @(negedge clk);
    checkOutput(tag, (sbQ.size() == 0), 1'b1);
  endtask

  // Monitor: every winrnd pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (winrnd) begin
      nAssert++;
      assert (sbQ.size() != 0) else begin
        nFail++;
        $error("[TB] FAIL unexpected_winrnd observed=pulse expected=none");
      end
      if (sbQ.size() != 0) begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("sb_right", right, e.right);
        checkOutput("sb_tie", tie, e.tie);
      end
      checkOutput("winrnd_one_cycle", prevWin, 1'b0);
    end else begin
      checkOutput("tie_without_winrnd", tie, 1'b0);
    end
    prevWin = winrnd;
  end

  initial begin
    nAssert = 0;
    nFail   = 0;
    prevWin = 1'b0;
    rst = 1'b0;
    pbL = 1'b0;
    pbR = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_winrnd", winrnd, 1'b0);
    checkOutput("rst_tie", tie, 1'b0);
    checkOutput("rst_right", right, 1'b0);
    checkOutput("rst_ready", ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(10);
    checkOutput("armed_after_reset", ready, 1'b1);

    // Same-cycle press on both buttons gives a tie, right stays 0
    sbQ.push_back('{right: 1'b0, tie: 1'b1});
    applyStimulus(1'b1, 1'b1);
    waitPulse("tie_pulse_seen", 20);
    checkOutput("tie_right_kept", right, 1'b0);
    idleCycles(5);
    applyStimulus(1'b0, 1'b0);
    waitReady("tie_rearm", 40);
    idleCycles(10);

    // Clean right press with exact latency
    checkOutput("ready_before_press", ready, 1'b1);
    sbQ.push_back('{right: 1'b1, tie: 1'b0});
    applyStimulus(1'b0, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("latency_not_early", winrnd, 1'b0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_winrnd", winrnd, 1'b1);
    checkOutput("latency_right", right, 1'b1);
    checkOutput("latency_ready_low", ready, 1'b0);
    @(negedge clk);
    checkOutput("pulse_ended", winrnd, 1'b0);
    checkOutput("ready_low_after", ready, 1'b0);
    idleCycles(1);
    applyStimulus(1'b0, 1'b0);
    waitReady("right_rearm", 40);
    checkOutput("queue_drained_right", (sbQ.size() == 0), 1'b1);

    // Left two cycles ahead of right: one round, left wins
    sbQ.push_back('{right: 1'b0, tie: 1'b0});
    applyStimulus(1'b1, 1'b0);
    idleCycles(1);
    applyStimulus(1'b1, 1'b1);
    idleCycles(20);
    checkOutput("stagger_single_pulse", (sbQ.size() == 0), 1'b1);
    checkOutput("stagger_right", right, 1'b0);
    checkOutput("stagger_not_ready", ready, 1'b0);
    applyStimulus(1'b0, 1'b0);
    idleCycles(3);
    checkOutput("stagger_release_wait", ready, 1'b0);
    waitReady("stagger_rearm", 40);

    // Fast toggling on the left never debounces
    for (int i = 0; i < 20; i++) begin
      applyStimulus(~pbL, 1'b0);
      checkOutput("toggle_ready", ready, 1'b1);
    end
    applyStimulus(1'b0, 1'b0);
    idleCycles(10);
    checkOutput("toggle_ready_end", ready, 1'b1);

    // Right held across reset release: nothing until released and re-pressed
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("hold_rst_ready", ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(20);
    checkOutput("hold_not_armed", ready, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitReady("hold_rearm", 40);
    sbQ.push_back('{right: 1'b1, tie: 1'b0});
    applyStimulus(1'b0, 1'b1);
    waitPulse("hold_repress_pulse", 20);
    checkOutput("hold_repress_right", right, 1'b1);
    applyStimulus(1'b0, 1'b0);
    waitReady("hold_repress_rearm", 40);

    // Reset pulse at the 4th edge of a left press aborts the round
    applyStimulus(1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("abort_winrnd", winrnd, 1'b0);
    checkOutput("abort_tie", tie, 1'b0);
    checkOutput("abort_right", right, 1'b0);
    checkOutput("abort_ready", ready, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    idleCycles(20);
    checkOutput("abort_not_armed", ready, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitReady("abort_rearm", 40);
    sbQ.push_back('{right: 1'b0, tie: 1'b0});
    applyStimulus(1'b1, 1'b0);
    waitPulse("abort_fresh_pulse", 20);
    checkOutput("abort_fresh_right", right, 1'b0);
    applyStimulus(1'b0, 1'b0);
    idleCycles(15);

    checkOutput("scoreboard_empty", (sbQ.size() == 0), 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
